pool_conv2_rr_arbiter: RTL and testbench

//  Round-robin read scheduler sharing the Conv2 input among N_CH pool->conv2 event FIFOs.
//  - Picks a non-empty FIFO and holds its read request until that FIFO returns one AER word.
//  - Forwards the word plus a channel tag to Conv2 over a valid/ready handshake.
//  - A timeout recovers from a FIFO that never answers.

---
 rtl/snn_fifo_pkg.sv | 15 +
 rtl/pool_conv2_rr_arbiter_rr_pick.sv | 28 ++
 rtl/pool_conv2_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_pool_conv2_rr_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_fifo_pkg.sv
// Shared encodings and constants for the pool->conv2 FIFO read path.
package snn_fifo_pkg;

  localparam int AER_W_DEF = 12;
  localparam int GAP_CYC   = 2;
  localparam int GAP_W     = 2;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_WAIT = 4'b0010,
    S_OUT  = 4'b0100,
    S_GAP  = 4'b1000
  } state_t;

endpackage

// File: rtl/pool_conv2_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first eligible channel strictly after last_grant, wrapping.
module rr_pick #(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] eligible_i,
  input  logic [CH_W-1:0] last_grant_i,
  output logic [CH_W-1:0] grant_o,
  output logic            any_o
);

  logic [CH_W-1:0] w_idx;

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    w_idx   = '0;
    // Offsets 1..N_CH so last_grant itself is considered last.
    for (int k = 1; k <= N_CH; k++) begin
      w_idx = CH_W'((int'(last_grant_i) + k) % N_CH);
      if (!any_o && eligible_i[w_idx]) begin
        any_o   = 1'b1;
        grant_o = w_idx;
      end
    end
  end

endmodule

// File: rtl/pool_conv2_rr_arbiter.sv
// Round-robin reader of N_CH event FIFOs feeding Conv2; valid one cycle after the granted flag, word held under aer_ready_i backpressure.
// Optional PERF_CNT_EN adds per-channel accepted-transfer counters on ev_cnt_o.
module pool_conv2_rr_arbiter
  import snn_fifo_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int AER_W   = AER_W_DEF,
  parameter  int TIMEOUT = 64,
  localparam int CH_W    = $clog2(N_CH),
  localparam int WCNT_W  = $clog2(TIMEOUT)
) (
  input  logic                    work_clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         ch_empty_i,
  input  logic [N_CH*AER_W-1:0]   ch_data_i,
  input  logic [N_CH-1:0]         ch_flag_i,
  output logic [N_CH-1:0]         ch_req_o,
  output logic [AER_W-1:0]        aer_o,
  output logic [CH_W-1:0]         aer_ch_o,
  output logic                    aer_valid_o,
  input  logic                    aer_ready_i,
`ifdef PERF_CNT_EN
  output logic [N_CH*16-1:0]      ev_cnt_o,
`endif
  output logic                    timeout_o
);

  state_t          r_state;
  logic [CH_W-1:0] r_last_grant;
  logic [CH_W-1:0] r_grant;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;

  logic [CH_W-1:0]  w_grant;
  logic             w_any;
  logic [N_CH-1:0]  w_onehot;
  logic [AER_W-1:0] w_sel_dat;
  logic             w_sel_flag;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .eligible_i   (~ch_empty_i),
    .last_grant_i (r_last_grant),
    .grant_o      (w_grant),
    .any_o        (w_any)
  );

  assign w_onehot = {{(N_CH-1){1'b0}}, 1'b1} << w_grant;

  // Only the granted channel's flag and data are looked at; the others are ignored.
  always_comb begin
    w_sel_dat  = '0;
    w_sel_flag = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_grant == CH_W'(i)) begin
        w_sel_dat  = ch_data_i[i*AER_W +: AER_W];
        w_sel_flag = ch_flag_i[i];
      end
    end
  end

  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= CH_W'(N_CH-1);
      r_grant      <= '0;
      r_wait_cnt   <= '0;
      r_gap_cnt    <= '0;
      ch_req_o     <= '0;
      aer_o        <= '0;
      aer_ch_o     <= '0;
      aer_valid_o  <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant    <= w_grant;
            ch_req_o   <= w_onehot;
            r_wait_cnt <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Flag is tested first so a flag on the last wait cycle is still taken.
          if (w_sel_flag) begin
            aer_o        <= w_sel_dat;
            aer_ch_o     <= r_grant;
            aer_valid_o  <= 1'b1;
            ch_req_o     <= '0;
            r_last_grant <= r_grant;
            r_state      <= S_OUT;
          end else if (r_wait_cnt == WCNT_W'(TIMEOUT-1)) begin
            ch_req_o     <= '0;
            timeout_o    <= 1'b1;
            r_last_grant <= r_grant;
            r_gap_cnt    <= '0;
            r_state      <= S_GAP;
          end else begin
            r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
          end
        end
        S_OUT: begin
          if (aer_ready_i) begin
            aer_valid_o <= 1'b0;
            r_gap_cnt   <= '0;
            r_state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_W'(GAP_CYC-1)) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          ch_req_o    <= '0;
          aer_valid_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [15:0] r_ev_cnt [N_CH];

  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) r_ev_cnt[i] <= '0;
    end else if (aer_valid_o && aer_ready_i) begin
      for (int i = 0; i < N_CH; i++) begin
        if (aer_ch_o == CH_W'(i)) r_ev_cnt[i] <= r_ev_cnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ev
    assign ev_cnt_o[g*16 +: 16] = r_ev_cnt[g];
  end
`endif

endmodule

// File: tb/tb_pool_conv2_rr_arbiter.sv
// Bench: FIFO responder model + round-robin reference + scoreboard for pool_conv2_rr_arbiter.
module tb_pool_conv2_rr_arbiter;

  localparam int N_CH    = 4;
  localparam int AER_W   = 12;
  localparam int TIMEOUT = 64;
  localparam int CH_W    = 2;
  localparam int LAT     = 3;

  logic                  work_clk = 1'b0;
  logic                  rst_n;
  logic [N_CH-1:0]       ch_empty_i;
  logic [N_CH*AER_W-1:0] ch_data_i;
  logic [N_CH-1:0]       ch_flag_i;
  logic [N_CH-1:0]       ch_req_o;
  logic [AER_W-1:0]      aer_o;
  logic [CH_W-1:0]       aer_ch_o;
  logic                  aer_valid_o;
  logic                  aer_ready_i;
  logic                  timeout_o;
`ifdef PERF_CNT_EN
  logic [N_CH*16-1:0]    ev_cnt_o;
`endif

  pool_conv2_rr_arbiter #(.N_CH(N_CH), .AER_W(AER_W), .TIMEOUT(TIMEOUT)) dut (
    .work_clk    (work_clk),
    .rst_n       (rst_n),
    .ch_empty_i  (ch_empty_i),
    .ch_data_i   (ch_data_i),
    .ch_flag_i   (ch_flag_i),
    .ch_req_o    (ch_req_o),
    .aer_o       (aer_o),
    .aer_ch_o    (aer_ch_o),
    .aer_valid_o (aer_valid_o),
    .aer_ready_i (aer_ready_i),
`ifdef PERF_CNT_EN
    .ev_cnt_o    (ev_cnt_o),
`endif
    .timeout_o   (timeout_o)
  );

  always #5 work_clk = ~work_clk;

  typedef struct packed {
    logic [AER_W-1:0] dat;
    logic [CH_W-1:0]  ch;
  } exp_t;

  int               checks   = 0;
  int               failures = 0;
  logic [AER_W-1:0] fq [N_CH][$];
  exp_t             sb [$];
  logic [N_CH-1:0]  dead = '0;
  logic [N_CH-1:0]  hide = '0;
  int               lat_cfg [N_CH];
  int               rdy_mode = 0;
  int               acc_cnt [N_CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rule: lowest eligible index above last, else lowest eligible overall.
  function automatic int rr_expect(input logic [N_CH-1:0] empty, input int last);
    int lowest;
    lowest = -1;
    for (int c = 0; c < N_CH; c++) begin
      if (!empty[c]) begin
        if (c > last) return c;
        if (lowest < 0) lowest = c;
      end
    end
    return lowest;
  endfunction

  logic [N_CH-1:0] smp_empty;
  logic            gflag_smp;
  always @(posedge work_clk) begin
    smp_empty <= ch_empty_i;
    gflag_smp <= |(ch_flag_i & ch_req_o);
  end

  // FIFO responder: answers a request after lat_cfg cycles unless the channel is dead.
  int rcnt, rc;
  logic [AER_W-1:0] rdat;
  exp_t rexp;
  initial begin
    ch_flag_i  = '0;
    ch_data_i  = '0;
    ch_empty_i = '1;
    rcnt       = 0;
    forever begin
      @(negedge work_clk);
      ch_flag_i = N_CH'($urandom) & ~ch_req_o;
      for (int c = 0; c < N_CH; c++) ch_data_i[c*AER_W +: AER_W] = AER_W'($urandom);
      if (!rst_n || ch_req_o == '0) begin
        rcnt = 0;
      end else begin
        rcnt++;
        rc = 0;
        for (int i = 0; i < N_CH; i++) if (ch_req_o[i]) rc = i;
        if (rcnt == lat_cfg[rc] && !dead[rc] && fq[rc].size() > 0) begin
          rdat = fq[rc].pop_front();
          ch_flag_i[rc] = 1'b1;
          ch_data_i[rc*AER_W +: AER_W] = rdat;
          rexp.dat = rdat;
          rexp.ch  = CH_W'(rc);
          sb.push_back(rexp);
        end
      end
      for (int c = 0; c < N_CH; c++) ch_empty_i[c] = (fq[c].size() == 0) || hide[c];
    end
  end

  initial begin
    aer_ready_i = 1'b0;
    forever begin
      @(posedge work_clk);
      #1;
      case (rdy_mode)
        0:       aer_ready_i = 1'b1;
        1:       aer_ready_i = 1'b0;
        default: aer_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: grant order, request timing, output handshake and scoreboard.
  logic [N_CH-1:0]  prev_req;
  logic             prev_valid, prev_acc, dead_at, exp_timeout;
  logic [AER_W-1:0] prev_aer;
  logic [CH_W-1:0]  prev_ch;
  int               m_last, cur_ch, hold, exp_hold, e;
  exp_t             mx;
  initial begin
    forever begin
      @(negedge work_clk);
      if (!rst_n) begin
        prev_req = '0; prev_valid = 1'b0; prev_acc = 1'b0; exp_timeout = 1'b0;
        m_last = N_CH-1; hold = 0; exp_hold = 0; dead_at = 1'b0; cur_ch = 0;
        sb.delete();
        for (int c = 0; c < N_CH; c++) acc_cnt[c] = 0;
      end else begin
        if (ch_req_o != '0 && prev_req == '0) begin
          e = rr_expect(smp_empty, m_last);
          if (e < 0) begin
            chk("grant_without_eligible", 32'(ch_req_o), 0);
          end else begin
            chk("grant_channel", 32'(ch_req_o), 32'(1) << e);
            cur_ch   = e;
            dead_at  = dead[e];
            exp_hold = dead[e] ? TIMEOUT : lat_cfg[e];
          end
          hold = 1;
        end else if (ch_req_o != '0) begin
          chk("req_held", 32'(ch_req_o), 32'(prev_req));
          hold++;
        end else if (prev_req != '0) begin
          chk("req_hold_len", hold, exp_hold);
          if (dead_at) exp_timeout = 1'b1;
          m_last = cur_ch;
        end
        chk("timeout_flag", 32'(timeout_o), 32'(exp_timeout));
        if (gflag_smp) chk("valid_after_flag", 32'(aer_valid_o), 1);
        if (aer_valid_o) chk("no_req_during_out", 32'(ch_req_o), 0);
        if (prev_valid && !prev_acc) begin
          chk("valid_held", 32'(aer_valid_o), 1);
          chk("aer_stable", 32'(aer_o), 32'(prev_aer));
          chk("ch_stable", 32'(aer_ch_o), 32'(prev_ch));
        end
        if (prev_acc) chk("valid_one_beat", 32'(aer_valid_o), 0);
        if (aer_valid_o && aer_ready_i) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got %0h on ch %0d, none expected", aer_o, aer_ch_o);
          end else begin
            mx = sb.pop_front();
            chk("aer_data", 32'(aer_o), 32'(mx.dat));
            chk("aer_ch", 32'(aer_ch_o), 32'(mx.ch));
          end
          acc_cnt[aer_ch_o]++;
        end
        prev_req   = ch_req_o;
        prev_valid = aer_valid_o;
        prev_acc   = aer_valid_o && aer_ready_i;
        prev_aer   = aer_o;
        prev_ch    = aer_ch_o;
      end
    end
  end

  task automatic push(input int c, input logic [AER_W-1:0] d);
    @(posedge work_clk);
    #1;
    fq[c].push_back(d);
  endtask

  task automatic wait_drain(input int budget);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge work_clk);
      n++;
      done = (sb.size() == 0) && !aer_valid_o && (ch_req_o == '0);
      for (int c = 0; c < N_CH; c++) if (fq[c].size() != 0) done = 1'b0;
    end
    chk("drain_in_budget", 32'(done), 1);
  endtask

  task automatic wait_cond_req(input int budget, input string name);
    int n;
    n = 0;
    while (ch_req_o == '0 && n < budget) begin
      @(negedge work_clk);
      n++;
    end
    chk(name, 32'(ch_req_o != '0), 1);
  endtask

`ifdef PERF_CNT_EN
  task automatic check_counters();
    for (int c = 0; c < N_CH; c++) chk("ev_cnt", 32'(ev_cnt_o[c*16 +: 16]), 32'(acc_cnt[c]));
  endtask
`endif

  initial begin
    int n;
    for (int c = 0; c < N_CH; c++) lat_cfg[c] = LAT;
    rst_n = 1'b0;
    repeat (3) @(posedge work_clk);
    @(negedge work_clk);
    chk("rst_req", 32'(ch_req_o), 0);
    chk("rst_valid", 32'(aer_valid_o), 0);
    chk("rst_aer", 32'(aer_o), 0);
    chk("rst_aer_ch", 32'(aer_ch_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    rst_n = 1'b1;

    // All FIFOs empty: nothing may be requested.
    repeat (50) begin
      @(negedge work_clk);
      chk("idle_req", 32'(ch_req_o), 0);
      chk("idle_valid", 32'(aer_valid_o), 0);
    end

    // Single channel, known word.
    push(2, 12'hA5C);
    wait_drain(200);

    // All channels busy: rotation without repeats.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < N_CH; c++) push(c, AER_W'($urandom));
    wait_drain(2000);

    // Flag on the very last wait cycle wins over the timeout.
    lat_cfg[2] = TIMEOUT;
    push(2, AER_W'($urandom));
    wait_drain(400);
    lat_cfg[2] = LAT;

    // Channel empties while its request is outstanding.
    push(3, AER_W'($urandom));
    wait_cond_req(100, "req_before_hide");
    hide[3] = 1'b1;
    wait_drain(200);
    hide[3] = 1'b0;

    // Dead channel 1: timeout, then next channel.
    dead[1] = 1'b1;
    push(1, AER_W'($urandom));
    push(2, AER_W'($urandom));
    n = 0;
    while (!timeout_o && n < 400) begin
      @(negedge work_clk);
      n++;
    end
    chk("timeout_seen", 32'(timeout_o), 1);
    dead[1] = 1'b0;
    wait_drain(1000);

    // Backpressure: ready low for 20 cycles while others wait.
    rdy_mode = 1;
    push(0, AER_W'($urandom));
    push(3, AER_W'($urandom));
    n = 0;
    while (!aer_valid_o && n < 100) begin
      @(negedge work_clk);
      n++;
    end
    chk("bp_valid_seen", 32'(aer_valid_o), 1);
    repeat (20) @(negedge work_clk);
    rdy_mode = 0;
    wait_drain(400);

    // Randomized traffic with random ready.
    rdy_mode = 2;
    repeat (400) begin
      @(posedge work_clk);
      #1;
      if ($urandom_range(0, 3) == 0) fq[$urandom_range(0, N_CH-1)].push_back(AER_W'($urandom));
    end
    rdy_mode = 0;
    wait_drain(4000);
`ifdef PERF_CNT_EN
    check_counters();
`endif

    // Reset in the middle of a wait.
    push(3, AER_W'($urandom));
    wait_cond_req(100, "req_before_reset");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(ch_req_o), 0);
    chk("mid_rst_valid", 32'(aer_valid_o), 0);
    chk("mid_rst_timeout", 32'(timeout_o), 0);
    chk("mid_rst_aer", 32'(aer_o), 0);
`ifdef PERF_CNT_EN
    chk("mid_rst_cnt", 32'(|ev_cnt_o), 0);
`endif
    repeat (3) @(negedge work_clk);
    rst_n = 1'b1;
    wait_drain(400);
`ifdef PERF_CNT_EN
    check_counters();
`endif
    chk("sb_empty_end", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
